// File: rtl/bin_to_seg_digits_pkg.sv
// Shared definitions for the binary-to-BCD digit converter feeding segment_scan.
// Optional build macro: BIN_TO_SEG_LZB_EN (leading-zero blanking of dat_en).
package bin_to_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int              DIGITS       = 8;
  localparam int              BCD_W        = 4 * DIGITS;
  localparam longint unsigned MAX_VAL      = 64'd99_999_999;
  localparam logic [3:0]      DEF_ERR_CODE = 4'hE;

endpackage

// File: rtl/bin_to_seg_digits_bcd_add3.sv
// Shift-and-add-3 correction cell: a BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // Combinational correction; the 4-bit wrap only matters for overflowed
  // inputs, whose digits are replaced by the error code anyway.
  always_comb begin
    o_nib = i_nib;
    if (i_nib >= 4'd5) begin
      o_nib = i_nib + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_seg_digits.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with start/busy/done
// handshake. Produces eight held digit codes plus the digit-enable mask.
// Optional build macro: BIN_TO_SEG_LZB_EN enables leading-zero blanking of
// dat_en; without it every non-overflow result enables all eight digits.
module bin_to_seg_digits
  import bin_to_seg_pkg::*;
#(
  parameter int         WIDTH    = 27,
  parameter logic [3:0] ERR_CODE = DEF_ERR_CODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  bin_in,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [3:0]        dig_1,
  output logic [3:0]        dig_2,
  output logic [3:0]        dig_3,
  output logic [3:0]        dig_4,
  output logic [3:0]        dig_5,
  output logic [3:0]        dig_6,
  output logic [3:0]        dig_7,
  output logic [3:0]        dig_8,
  output logic [DIGITS-1:0] dat_en
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef BIN_TO_SEG_LZB_EN
  localparam logic [DIGITS-1:0] RST_EN = {{(DIGITS-1){1'b0}}, 1'b1};
`else
  localparam logic [DIGITS-1:0] RST_EN = '1;
`endif

  localparam logic [DIGITS-1:0] OVF_EN  = {{(DIGITS-1){1'b0}}, 1'b1};
  localparam logic [BCD_W-1:0]  OVF_DIG = {{(BCD_W-4){1'b0}}, ERR_CODE};

`ifdef BIN_TO_SEG_LZB_EN
  // Enable every digit up to the most significant non-zero one; the
  // rightmost digit is always lit so zero still shows "0".
  function automatic logic [DIGITS-1:0] lzb_mask(input logic [BCD_W-1:0] bcd);
    logic [DIGITS-1:0] m;
    m = {{(DIGITS-1){1'b0}}, 1'b1};
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        m = DIGITS'((1 << (i + 1)) - 1);
      end
    end
    return m;
  endfunction
`endif

  state_t             r_state;
  logic [WIDTH-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic [BCD_W-1:0]   r_dig;
  logic [DIGITS-1:0]  r_dat_en;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_shift;
  logic [WIDTH-1:0]   w_bin_shift;
  logic               w_ovf_in;
  logic               w_last;
  logic [DIGITS-1:0]  w_mask;

  // Per-digit add-3 correction ahead of the shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib (r_bcd[4*g +: 4]),
      .o_nib (w_adj[4*g +: 4])
    );
  end

  // One shift step of {bcd, bin}; the carry out of the top nibble is dropped
  assign w_bcd_shift = (w_adj << 1) | BCD_W'(r_bin[WIDTH-1]);
  assign w_bin_shift = r_bin << 1;
  assign w_ovf_in    = 64'(bin_in) > MAX_VAL;
  assign w_last      = (r_cnt == LAST_CNT);

`ifdef BIN_TO_SEG_LZB_EN
  assign w_mask = lzb_mask(w_bcd_shift);
`else
  assign w_mask = '1;
`endif

  // Conversion FSM; held outputs are loaded on the final shift so they
  // appear together with the done pulse in the DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_dig      <= '0;
      r_dat_en   <= RST_EN;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin      <= bin_in;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= w_ovf_in;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_shift;
          r_bin <= w_bin_shift;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (r_ovf_pend) begin
              r_ovf    <= 1'b1;
              r_dig    <= OVF_DIG;
              r_dat_en <= OVF_EN;
            end else begin
              r_ovf    <= 1'b0;
              r_dig    <= w_bcd_shift;
              r_dat_en <= w_mask;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign ovf    = r_ovf;
  assign dat_en = r_dat_en;
  assign dig_1  = r_dig[3:0];
  assign dig_2  = r_dig[7:4];
  assign dig_3  = r_dig[11:8];
  assign dig_4  = r_dig[15:12];
  assign dig_5  = r_dig[19:16];
  assign dig_6  = r_dig[23:20];
  assign dig_7  = r_dig[27:24];
  assign dig_8  = r_dig[31:28];

endmodule
